// File: rtl/microcode_sequencer_if.sv
// Handshake and ROM-field bundle between the micro-sequencer and its
// surroundings (microcode ROM, opcode decoder, matmul datapath).
interface microcode_sequencer_if #(
  parameter int ADDR_W = 16
);
  logic              start;
  logic              stall;
  logic              z_flag;
  logic [ADDR_W-1:0] dispatch_addr;
  logic [1:0]        condition;
  logic              bt;
  logic [ADDR_W-1:0] jump_addr;
  logic [ADDR_W-1:0] upc;
  logic              ops_en;
  logic              busy;
  logic              done;
  logic              err;

  // Sequencer side: owns the micro-address and the status outputs.
  modport master (
    input  start, stall, z_flag, dispatch_addr, condition, bt, jump_addr,
    output upc, ops_en, busy, done, err
  );

  // Environment side: ROM, decoder and datapath.
  modport slave (
    output start, stall, z_flag, dispatch_addr, condition, bt, jump_addr,
    input  upc, ops_en, busy, done, err
  );
endinterface

// File: rtl/microcode_sequencer.sv
// Micro-program counter and next-address logic for the control unit.
// upc addresses a combinational ROM; the word at upc executes in the same
// cycle and its branch fields pick the address loaded on the next edge.
module microcode_sequencer #(
  parameter int ADDR_W     = 16,
  parameter int DEPTH      = 86,
  parameter int START_ADDR = 1,
  parameter int FETCH_ADDR = 1
) (
  input logic                    clk,
  input logic                    rst_n,
  microcode_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] FETCH_A = ADDR_W'(FETCH_ADDR);
  // One extra bit so that upc+1 wrapping from all-ones reads as out of range.
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_X   = (ADDR_W+1)'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] upc_q, upc_d;
  logic              err_q, err_d;
  logic [ADDR_W:0]   inc_x;
  logic [ADDR_W:0]   target_x;
  logic              halt;
  logic              halt_err;

  // State, micro-PC and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      upc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
      err_q   <= err_d;
    end
  end

  // Next-state and next-address selection from the branch fields.
  always_comb begin
    state_d  = state_q;
    upc_d    = upc_q;
    err_d    = err_q;
    inc_x    = {1'b0, upc_q} + ONE_X;
    target_x = inc_x;
    halt     = 1'b0;
    halt_err = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          upc_d   = START_A;
          err_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (!bus.stall) begin
          if (!bus.bt) begin
            case (bus.condition)
              2'b00: target_x = inc_x;
              2'b01: target_x = bus.z_flag  ? {1'b0, bus.jump_addr} : inc_x;
              2'b10: target_x = !bus.z_flag ? {1'b0, bus.jump_addr} : inc_x;
              default: target_x = {1'b0, bus.jump_addr};
            endcase
          end else begin
            case (bus.condition)
              2'b00: target_x = {1'b0, FETCH_A};
              2'b01: target_x = {1'b0, bus.dispatch_addr};
              2'b10: halt = 1'b1;
              default: begin
                halt     = 1'b1;
                halt_err = 1'b1;
              end
            endcase
          end
          if (halt) begin
            state_d = S_DONE;
            err_d   = err_q | halt_err;
          end else if (target_x >= DEPTH_X) begin
            // Out-of-range target: leave upc on the offending word.
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            upc_d = target_x[ADDR_W-1:0];
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        upc_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        upc_d   = '0;
      end
    endcase
  end

  // Status outputs decode straight from registered state so reset clears them at once.
  assign bus.upc    = upc_q;
  assign bus.busy   = (state_q == S_RUN);
  assign bus.ops_en = (state_q == S_RUN) && !bus.stall;
  assign bus.done   = (state_q == S_DONE);
  assign bus.err    = err_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed bench for microcode_sequencer with a small behavioural ROM.
module tb_microcode_sequencer;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  logic        rom_bt   [0:127];
  logic [1:0]  rom_cond [0:127];
  logic [15:0] rom_jmp  [0:127];

  microcode_sequencer_if #(.ADDR_W(16)) bus ();

  microcode_sequencer #(
    .ADDR_W(16), .DEPTH(86), .START_ADDR(1), .FETCH_ADDR(1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ROM model indexed by upc.
  always_comb begin
    bus.bt        = 1'b0;
    bus.condition = 2'b00;
    bus.jump_addr = 16'd0;
    if (bus.upc < 16'd128) begin
      bus.bt        = rom_bt[bus.upc[6:0]];
      bus.condition = rom_cond[bus.upc[6:0]];
      bus.jump_addr = rom_jmp[bus.upc[6:0]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 128; i++) begin
      rom_bt[i]   = 1'b0;
      rom_cond[i] = 2'b00;
      rom_jmp[i]  = 16'd0;
    end
  endtask

  task automatic set_word(input int a, input logic b, input logic [1:0] c, input logic [15:0] j);
    rom_bt[a]   = b;
    rom_cond[a] = c;
    rom_jmp[a]  = j;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout done=%b exp 1", tag, bus.done);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++; if (bus.upc !== 16'd0)  begin errors++; $display("FAIL rst_upc got %0d exp 0", bus.upc); end
    checks++; if (bus.busy !== 1'b0)  begin errors++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
    checks++; if (bus.ops_en !== 1'b0) begin errors++; $display("FAIL rst_ops_en got %b exp 0", bus.ops_en); end
    checks++; if (bus.done !== 1'b0)  begin errors++; $display("FAIL rst_done got %b exp 0", bus.done); end
    checks++; if (bus.err !== 1'b0)   begin errors++; $display("FAIL rst_err got %b exp 0", bus.err); end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (bus.upc !== 16'd0 || bus.busy !== 1'b0) begin errors++; $display("FAIL idle_after_rst upc=%0d busy=%b exp 0/0", bus.upc, bus.busy); end
  endtask

  task automatic test_sequential();
    int ops;
    ops = 0;
    clear_rom();
    set_word(4, 1'b1, 2'b10, 16'd0);
    do_start();
    for (int i = 1; i <= 4; i++) begin
      checks++; if (bus.upc !== 16'(i) || bus.busy !== 1'b1) begin errors++; $display("FAIL seq_upc got %0d busy=%b exp %0d busy=1", bus.upc, bus.busy, i); end
      if (bus.ops_en === 1'b1) ops++;
      tick();
    end
    checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.ops_en !== 1'b0 || bus.err !== 1'b0) begin
      errors++; $display("FAIL seq_done done=%b busy=%b ops_en=%b err=%b exp 1/0/0/0", bus.done, bus.busy, bus.ops_en, bus.err); end
    checks++; if (ops !== 4) begin errors++; $display("FAIL seq_ops_en_cycles got %0d exp 4", ops); end
    tick();
    checks++; if (bus.done !== 1'b0 || bus.upc !== 16'd0) begin errors++; $display("FAIL seq_idle done=%b upc=%0d exp 0/0", bus.done, bus.upc); end
  endtask

  task automatic run_branch(input logic [1:0] c, input logic z, input logic [15:0] exp, input string tag);
    clear_rom();
    set_word(1, 1'b0, 2'b11, 16'd10);
    set_word(10, 1'b0, c, 16'd40);
    set_word(11, 1'b1, 2'b10, 16'd0);
    set_word(40, 1'b1, 2'b10, 16'd0);
    bus.z_flag = z;
    do_start();
    tick();
    checks++; if (bus.upc !== 16'd10) begin errors++; $display("FAIL %s_jmp10 got %0d exp 10", tag, bus.upc); end
    tick();
    checks++; if (bus.upc !== exp) begin errors++; $display("FAIL %s upc got %0d exp %0d", tag, bus.upc, exp); end
    wait_done(tag);
    tick();
    bus.z_flag = 1'b0;
  endtask

  task automatic test_cond_branch();
    run_branch(2'b01, 1'b1, 16'd40, "cond01_z1");
    run_branch(2'b01, 1'b0, 16'd11, "cond01_z0");
    run_branch(2'b10, 1'b1, 16'd11, "cond10_z1");
    run_branch(2'b10, 1'b0, 16'd40, "cond10_z0");
  endtask

  task automatic test_stall();
    clear_rom();
    set_word(7, 1'b0, 2'b01, 16'd50);
    set_word(8, 1'b1, 2'b10, 16'd0);
    set_word(50, 1'b1, 2'b10, 16'd0);
    bus.z_flag = 1'b0;
    do_start();
    for (int i = 0; i < 6; i++) tick();
    checks++; if (bus.upc !== 16'd7 || bus.ops_en !== 1'b1) begin errors++; $display("FAIL stall_pre upc=%0d ops_en=%b exp 7/1", bus.upc, bus.ops_en); end
    bus.stall = 1'b1;
    #1;
    checks++; if (bus.ops_en !== 1'b0) begin errors++; $display("FAIL stall_ops_en_comb got %b exp 0", bus.ops_en); end
    for (int i = 0; i < 3; i++) begin
      bus.z_flag = ~bus.z_flag;
      tick();
      checks++; if (bus.upc !== 16'd7 || bus.ops_en !== 1'b0) begin errors++; $display("FAIL stall_hold upc=%0d ops_en=%b exp 7/0", bus.upc, bus.ops_en); end
    end
    bus.z_flag = 1'b0;
    bus.stall  = 1'b0;
    #1;
    checks++; if (bus.ops_en !== 1'b1) begin errors++; $display("FAIL stall_release_ops_en got %b exp 1", bus.ops_en); end
    tick();
    checks++; if (bus.upc !== 16'd8) begin errors++; $display("FAIL stall_release_upc got %0d exp 8", bus.upc); end
    wait_done("stall");
    tick();
  endtask

  task automatic test_dispatch_fetch();
    clear_rom();
    set_word(1, 1'b1, 2'b01, 16'd0);
    set_word(56, 1'b1, 2'b00, 16'd0);
    set_word(60, 1'b1, 2'b10, 16'd0);
    bus.dispatch_addr = 16'd55;
    do_start();
    tick();
    checks++; if (bus.upc !== 16'd55) begin errors++; $display("FAIL dispatch_55 got %0d exp 55", bus.upc); end
    tick();
    checks++; if (bus.upc !== 16'd56) begin errors++; $display("FAIL dispatch_seq got %0d exp 56", bus.upc); end
    tick();
    checks++; if (bus.upc !== 16'd1) begin errors++; $display("FAIL fetch_addr got %0d exp 1", bus.upc); end
    bus.dispatch_addr = 16'd60;
    tick();
    checks++; if (bus.upc !== 16'd60) begin errors++; $display("FAIL dispatch_60 got %0d exp 60", bus.upc); end
    bus.stall = 1'b1;
    tick();
    tick();
    checks++; if (bus.done !== 1'b0 || bus.upc !== 16'd60 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL halt_stalled done=%b upc=%0d busy=%b exp 0/60/1", bus.done, bus.upc, bus.busy); end
    bus.stall = 1'b0;
    tick();
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL halt_after_stall done=%b exp 1", bus.done); end
    tick();
    bus.dispatch_addr = 16'd0;
  endtask

  task automatic test_illegal();
    clear_rom();
    set_word(1, 1'b0, 2'b11, 16'd90);
    do_start();
    tick();
    checks++; if (bus.done !== 1'b1 || bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.upc !== 16'd1) begin
      errors++; $display("FAIL illegal_jmp done=%b err=%b busy=%b upc=%0d exp 1/1/0/1", bus.done, bus.err, bus.busy, bus.upc); end
    tick();
    checks++; if (bus.done !== 1'b0 || bus.err !== 1'b1 || bus.upc !== 16'd0) begin
      errors++; $display("FAIL illegal_sticky done=%b err=%b upc=%0d exp 0/1/0", bus.done, bus.err, bus.upc); end
    clear_rom();
    set_word(3, 1'b1, 2'b10, 16'd0);
    do_start();
    checks++; if (bus.err !== 1'b0 || bus.upc !== 16'd1) begin errors++; $display("FAIL start_clears_err err=%b upc=%0d exp 0/1", bus.err, bus.upc); end
    bus.start = 1'b1;
    tick();
    tick();
    checks++; if (bus.upc !== 16'd3) begin errors++; $display("FAIL start_ignored_run upc=%0d exp 3", bus.upc); end
    bus.start = 1'b0;
    tick();
    checks++; if (bus.done !== 1'b1 || bus.err !== 1'b0) begin errors++; $display("FAIL clean_halt done=%b err=%b exp 1/0", bus.done, bus.err); end
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.upc !== 16'd0) begin errors++; $display("FAIL clean_idle busy=%b upc=%0d exp 0/0", bus.busy, bus.upc); end
  endtask

  task automatic test_boundary();
    clear_rom();
    set_word(1, 1'b0, 2'b11, 16'd85);
    do_start();
    tick();
    checks++; if (bus.upc !== 16'd85 || bus.err !== 1'b0) begin errors++; $display("FAIL last_word upc=%0d err=%b exp 85/0", bus.upc, bus.err); end
    tick();
    checks++; if (bus.done !== 1'b1 || bus.err !== 1'b1 || bus.upc !== 16'd85) begin
      errors++; $display("FAIL inc_past_depth done=%b err=%b upc=%0d exp 1/1/85", bus.done, bus.err, bus.upc); end
    tick();
    clear_rom();
    set_word(1, 1'b1, 2'b11, 16'd0);
    do_start();
    tick();
    checks++; if (bus.done !== 1'b1 || bus.err !== 1'b1) begin errors++; $display("FAIL reserved_halt done=%b err=%b exp 1/1", bus.done, bus.err); end
    tick();
  endtask

  task automatic test_reset_midrun();
    clear_rom();
    do_start();
    for (int i = 0; i < 4; i++) tick();
    checks++; if (bus.upc !== 16'd5 || bus.busy !== 1'b1) begin errors++; $display("FAIL midrun_pre upc=%0d busy=%b exp 5/1", bus.upc, bus.busy); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.upc !== 16'd0 || bus.busy !== 1'b0 || bus.ops_en !== 1'b0 || bus.err !== 1'b0) begin
      errors++; $display("FAIL midrun_reset upc=%0d busy=%b ops_en=%b err=%b exp 0/0/0/0", bus.upc, bus.busy, bus.ops_en, bus.err); end
    #2;
    rst_n = 1'b1;
    tick();
    checks++; if (bus.upc !== 16'd0 || bus.busy !== 1'b0) begin errors++; $display("FAIL midrun_idle upc=%0d busy=%b exp 0/0", bus.upc, bus.busy); end
  endtask

  initial begin
    errors            = 0;
    checks            = 0;
    rst_n             = 1'b0;
    bus.start         = 1'b0;
    bus.stall         = 1'b0;
    bus.z_flag        = 1'b0;
    bus.dispatch_addr = 16'd0;
    clear_rom();
    test_reset();
    test_sequential();
    test_cond_branch();
    test_stall();
    test_dispatch_fetch();
    test_illegal();
    test_boundary();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
